// File: rtl/controlunit.sv
// Multi-cycle instruction control FSM: IDLE -> FETCH -> DECODE -> EXEC -> WB.
// Optional HALT latch on opcode F is enabled by defining CU_HALT_EN.
module controlunit #(
  parameter int OPW = 4,
  parameter int AFW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [OPW-1:0] OP,
  output logic           clk_out,
  output logic           immed_sel,
  output logic           w_en,
  output logic [AFW-1:0] alu_func,
  output logic           flag_en,
  output logic           mem_sel,
  output logic           mem_en,
  output logic           pc_sel
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [OPW-1:0] op_reg, op_next;
  logic           halted_reg, halted_next;

  // Per-opcode control word, before phase gating
  logic [AFW-1:0] dec_alu;
  logic           dec_immed, dec_flag, dec_w, dec_memsel, dec_memen, dec_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    halted_next = halted_reg;
    if (halted_reg) begin
      state_next = IDLE;
    end else if (en) begin
      case (state_reg)
        IDLE:   state_next = FETCH;
        FETCH:  state_next = DECODE;
        DECODE: begin
          state_next = EXEC;
          op_next    = OP;
        end
        EXEC:   state_next = WB;
        WB: begin
          state_next = FETCH;
`ifdef CU_HALT_EN
          if (op_reg == 4'hF) begin
            state_next  = IDLE;
            halted_next = 1'b1;
          end
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    dec_alu    = '0;
    dec_immed  = 1'b0;
    dec_flag   = 1'b0;
    dec_w      = 1'b0;
    dec_memsel = 1'b0;
    dec_memen  = 1'b0;
    dec_pc     = 1'b0;
    if (!op_reg[3]) begin
      // Register-register ALU ops: function code equals the opcode
      dec_alu  = {1'b0, op_reg[2:0]};
      dec_flag = 1'b1;
      dec_w    = 1'b1;
    end else begin
      case (op_reg[2:0])
        3'd0, 3'd1: begin
          dec_alu   = {3'b000, op_reg[0]};
          dec_immed = 1'b1;
          dec_flag  = 1'b1;
          dec_w     = 1'b1;
        end
        3'd2: begin
          dec_immed  = 1'b1;
          dec_w      = 1'b1;
          dec_memsel = 1'b1;
        end
        3'd3: begin
          dec_immed = 1'b1;
          dec_memen = 1'b1;
        end
        3'd4: begin
          dec_alu  = 4'd1;
          dec_flag = 1'b1;
        end
        3'd5: begin
          dec_immed = 1'b1;
          dec_pc    = 1'b1;
        end
        3'd6: begin
          dec_alu = 4'd8;
          dec_w   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    clk_out   = 1'b0;
    immed_sel = 1'b0;
    w_en      = 1'b0;
    alu_func  = '0;
    flag_en   = 1'b0;
    mem_sel   = 1'b0;
    mem_en    = 1'b0;
    pc_sel    = 1'b0;
    if (en && (state_reg == EXEC || state_reg == WB)) begin
      alu_func  = dec_alu;
      immed_sel = dec_immed;
      mem_sel   = dec_memsel;
      if (state_reg == EXEC) begin
        flag_en = dec_flag;
        mem_en  = dec_memen;
      end else begin
        w_en    = dec_w;
        pc_sel  = dec_pc;
        clk_out = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controlunit.sv
// Self-checking bench for controlunit: directed opcode sweep, then randomized
// en/OP/rst stimulus compared every cycle against a phase-counter reference model.
module tb_controlunit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] OP  = 4'h0;
  logic       clk_out, immed_sel, w_en, flag_en, mem_sel, mem_en, pc_sel;
  logic [3:0] alu_func;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 exec, 4 write-back
  int       m_phase = 0;
  logic [3:0] m_op  = 4'h0;
  bit       m_halt  = 1'b0;

  always #5 clk = ~clk;

  controlunit dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .OP        (OP),
    .clk_out   (clk_out),
    .immed_sel (immed_sel),
    .w_en      (w_en),
    .alu_func  (alu_func),
    .flag_en   (flag_en),
    .mem_sel   (mem_sel),
    .mem_en    (mem_en),
    .pc_sel    (pc_sel)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Opcode table: {alu_func, immed, flag_en, w_en, mem_sel, mem_en, pc_sel}
  function automatic logic [9:0] table_row(input logic [3:0] op);
    case (op)
      4'h0: return {4'd0, 6'b011000};
      4'h1: return {4'd1, 6'b011000};
      4'h2: return {4'd2, 6'b011000};
      4'h3: return {4'd3, 6'b011000};
      4'h4: return {4'd4, 6'b011000};
      4'h5: return {4'd5, 6'b011000};
      4'h6: return {4'd6, 6'b011000};
      4'h7: return {4'd7, 6'b011000};
      4'h8: return {4'd0, 6'b111000};
      4'h9: return {4'd1, 6'b111000};
      4'hA: return {4'd0, 6'b101100};
      4'hB: return {4'd0, 6'b100010};
      4'hC: return {4'd1, 6'b010000};
      4'hD: return {4'd0, 6'b100001};
      4'hE: return {4'd8, 6'b001000};
      default: return 10'd0;
    endcase
  endfunction

  // Expected {clk_out, immed_sel, w_en, alu_func, flag_en, mem_sel, mem_en, pc_sel}
  function automatic logic [10:0] expected_outputs();
    logic [9:0] r;
    logic [10:0] e;
    r = table_row(m_op);
    e = '0;
    if (en && m_phase == 3)
      e = {1'b0, r[5], 1'b0, r[9:6], r[4], r[2], r[1], 1'b0};
    else if (en && m_phase == 4)
      e = {1'b1, r[5], r[3], r[9:6], 1'b0, r[2], 1'b0, r[0]};
    return e;
  endfunction

  function automatic void model_edge(input bit r_v, input bit en_v, input logic [3:0] op_v);
    if (r_v) begin
      m_phase = 0;
      m_op    = 4'h0;
      m_halt  = 1'b0;
    end else if (!m_halt && en_v) begin
      if (m_phase == 2) m_op = op_v;
      if (m_phase == 4) begin
`ifdef CU_HALT_EN
        if (m_op == 4'hF) begin
          m_halt  = 1'b1;
          m_phase = 0;
        end else
`endif
          m_phase = 1;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endfunction

  task automatic step(input bit r_v, input bit en_v, input logic [3:0] op_v, input string tag);
    logic [10:0] exp;
    @(negedge clk);
    rst = r_v;
    en  = en_v;
    OP  = op_v;
    @(posedge clk);
    void'(model_edge(r_v, en_v, op_v));
    #1;
    exp = expected_outputs();
    check_eq(tag, {5'd0, clk_out, immed_sel, w_en, alu_func, flag_en, mem_sel, mem_en, pc_sel},
             {5'd0, exp});
    if (exp[10])
      $display("txn op=%h outputs=%b", m_op,
               {clk_out, immed_sel, w_en, alu_func, flag_en, mem_sel, mem_en, pc_sel});
  endtask

  initial begin
    logic [3:0] dir_ops [8];
    logic [3:0] op_v;
    dir_ops = '{4'h0, 4'h1, 4'hB, 4'hA, 4'hD, 4'hC, 4'hE, 4'h9};

    step(1'b1, 1'b0, 4'h0, "reset");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, "idle_en0");

    // Each opcode held only in DECODE; other cycles drive junk OP
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 5; c++) begin
        op_v = (m_phase == 2) ? dir_ops[k] : 4'($urandom);
        step(1'b0, 1'b1, op_v, "directed_op");
        if (m_phase == 4) break;
      end
    end

    // Stall for 3 cycles in EXEC, then resume
    for (int c = 0; c < 6 && m_phase != 3; c++)
      step(1'b0, 1'b1, (m_phase == 2) ? 4'h2 : 4'h5, "to_exec");
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 4'h7, "stall_exec");
    step(1'b0, 1'b1, 4'h7, "resume_exec");
    step(1'b0, 1'b1, 4'h7, "resume_wb");

    // HALT opcode, then several cycles with en=1
    for (int c = 0; c < 6 && m_phase != 2; c++) step(1'b0, 1'b1, 4'h0, "to_decode");
    for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 4'hF, "halt_op");
    step(1'b1, 1'b1, 4'h0, "reset_after_halt");

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8), 4'($urandom), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/controlunit.md
Name: controlunit

Overview:
- Multi-cycle instruction control FSM for the 16-bit processor.
- Latches the 4-bit opcode and steps through FETCH/DECODE/EXEC/WB.
- Drives datapath selects, ALU function, register/flag/memory write enables, PC select and a per-instruction step strobe (clk_out).
- Sits between the instruction register and the datapath (regfile, ALU, flags, data memory, PC).

Parameters:
- OPW, 4, opcode width (fixed; 16 opcodes).
- AFW, 4, alu_func width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- en  input  1  run enable; low stalls the FSM.
- OP  input  4  opcode from instruction register.
- clk_out  output  1  instruction-step strobe; high for the one WB cycle.
- immed_sel  output  1  ALU B operand: 1 = immediate, 0 = register.
- w_en  output  1  register-file write enable.
- alu_func  output  4  ALU operation code.
- flag_en  output  1  flag register update enable.
- mem_sel  output  1  register write-back source: 1 = memory data, 0 = ALU.
- mem_en  output  1  data memory write enable.
- pc_sel  output  1  PC next source: 1 = jump target, 0 = PC+1.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB (state register, 3 bits).
- Reset (rst=1 at a clock edge): state=IDLE, op_q=0, halted=0. All outputs 0 from the cycle after that edge.
- IDLE -> FETCH when en=1; stays in IDLE while en=0.
- Sequence FETCH -> DECODE -> EXEC -> WB -> FETCH, one clock per state: 4 cycles per instruction.
- en=0 in any non-IDLE state: state and op_q hold, all outputs forced 0. Resumes in the same state when en returns to 1. No instruction is aborted.
- op_q <= OP on the clock edge leaving DECODE. OP is ignored in all other states.
- Outputs are combinational from (state, op_q, en).
- In IDLE, FETCH, DECODE all outputs are 0.
- alu_func, immed_sel, mem_sel are valid in EXEC and WB; 0 otherwise.
- flag_en and mem_en are asserted only in EXEC. w_en, pc_sel and clk_out are asserted only in WB.
- Opcode map (alu_func / immed_sel / flag_en / w_en / mem_sel / mem_en / pc_sel):
  - 0 ADD: 0/0/1/1/0/0/0
  - 1 SUB: 1/0/1/1/0/0/0
  - 2 AND: 2/0/1/1/0/0/0
  - 3 OR: 3/0/1/1/0/0/0
  - 4 XOR: 4/0/1/1/0/0/0
  - 5 NOT: 5/0/1/1/0/0/0
  - 6 SHL: 6/0/1/1/0/0/0
  - 7 SHR: 7/0/1/1/0/0/0
  - 8 ADDI: 0/1/1/1/0/0/0
  - 9 SUBI: 1/1/1/1/0/0/0
  - A LOAD: 0/1/0/1/1/0/0 (address = reg + immediate)
  - B STORE: 0/1/0/0/0/1/0
  - C CMP: 1/0/1/0/0/0/0
  - D JMP: 0/1/0/0/0/0/1
  - E MOV: 8 (pass B)/0/0/1/0/0/0
  - F HALT: all 0 (see Optional Feature)
- clk_out is 1 in WB for every opcode, including HALT.
- rst asserted mid-instruction: next state IDLE, no WB strobe for the partial instruction.

Optional Feature:
- Macro CU_HALT_EN.
- Defined: opcode F sets the halted latch at the WB edge. The FSM then goes to IDLE and stays there regardless of en, outputs 0, until rst.
- Undefined: opcode F behaves as NOP (all control 0 except clk_out in WB). The FSM continues to FETCH.

Test Plan:
- rst=1 one cycle, en=0 for 4 cycles -> state IDLE, every output 0.
- en=1, OP=0 -> cycles 3–4 after leaving IDLE: EXEC shows alu_func=0, flag_en=1; WB shows w_en=1, clk_out=1, mem_en=0, pc_sel=0.
- en=1, OP=1 steady -> EXEC alu_func=1, flag_en=1; WB w_en=1. OP changed to 0 during EXEC does not affect outputs.
- OP=B (STORE) -> EXEC mem_en=1, immed_sel=1; WB w_en=0. OP=A (LOAD) -> WB w_en=1, mem_sel=1.
- OP=D -> WB pc_sel=1, w_en=0. OP=C -> EXEC flag_en=1, WB w_en=0.
- en dropped for 3 cycles in EXEC -> outputs 0, state held; en=1 -> EXEC outputs reappear, then WB. With CU_HALT_EN, OP=F -> IDLE held with en=1 until rst.
